mux_n_hs: RTL and testbench



---
 rtl/mux_hs_pkg.sv | 33 +++
 rtl/hs_skid2.sv | 48 ++++
 rtl/mux_n_hs.sv | 101 ++++++++++
 tb/tb_mux_n_hs.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mux_hs_pkg.sv
// Shared definitions for the N-way handshake multiplexer: mode encodings and
// the round-robin search helper.
package mux_hs_pkg;

  localparam int MODE_SEL = 0;
  localparam int MODE_RR  = 1;

  typedef struct packed {
    logic       found;
    logic [3:0] idx;
  } rr_pick_t;

  // First set bit of valid[n-1:0], scanning upward from ptr and wrapping at n.
  function automatic rr_pick_t rr_pick(input logic [15:0] valid,
                                       input logic [3:0]  ptr,
                                       input int          n);
    rr_pick_t r;
    int j;
    r = '0;
    for (int i = 0; i < 16; i++) begin
      if (i < n && !r.found) begin
        j = int'(ptr) + i;
        if (j >= n) j = j - n;
        if (valid[j]) begin
          r.found = 1'b1;
          r.idx   = 4'(j);
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/hs_skid2.sv
// Two-entry FIFO used as the output skid buffer; head entry is presented
// directly, and push is refused while both entries are occupied.
module hs_skid2 #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [DW-1:0] push_data,
  input  logic          pop,
  output logic [DW-1:0] head,
  output logic          valid,
  output logic [1:0]    count
);

  logic [DW-1:0] mem [2];
  logic          wr_ptr;
  logic          rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign valid   = (count != 2'd0);
  assign do_pop  = pop && valid;
  assign do_push = push && (count != 2'd2);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (do_pop) rd_ptr <= ~rd_ptr;
      case ({do_push, do_pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/mux_n_hs.sv
// N-way valid/ready multiplexer steered either by a select token stream or by
// a round-robin pointer, merging into a single skid-buffered output channel.
module mux_n_hs
  import mux_hs_pkg::*;
#(
  parameter  int N   = 4,
  parameter  int W   = 8,
  parameter  int ARB = MODE_SEL,
  localparam int SW  = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           sel_valid,
  output logic           sel_ready,
  input  logic [SW-1:0]  sel_data,
  input  logic [N-1:0]   in_valid,
  output logic [N-1:0]   in_ready,
  input  logic [N*W-1:0] in_data,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [W-1:0]   out_data,
  output logic [SW-1:0]  out_src,
  output logic           err_sel
);

  logic [1:0]      count;
  logic            space;
  logic            fire;
  logic            drop;
  logic            sel_in_range;
  logic            sel_hit;
  logic [SW-1:0]   grant;
  logic [SW-1:0]   ptr;
  logic [W-1:0]    pick_data;
  logic [W+SW-1:0] head;
  rr_pick_t        pick;

  // Space comes from the registered count only, so out_ready never reaches
  // in_ready/sel_ready combinationally.
  assign space = (count != 2'd2);

  always_comb begin
    pick         = rr_pick(16'(in_valid), 4'(ptr), N);
    sel_in_range = (32'(sel_data) < N);
    sel_hit      = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (sel_data == SW'(i)) sel_hit = in_valid[i];
    end

    fire      = 1'b0;
    drop      = 1'b0;
    grant     = '0;
    sel_ready = 1'b0;
    if (!rst) begin
      if (ARB == MODE_RR) begin
        grant = SW'(pick.idx);
        fire  = pick.found && space;
      end else begin
        grant     = sel_data;
        fire      = sel_valid && sel_in_range && sel_hit && space;
        drop      = sel_valid && !sel_in_range;
        sel_ready = fire || drop;
      end
    end

    in_ready  = '0;
    pick_data = '0;
    for (int i = 0; i < N; i++) begin
      if (grant == SW'(i)) pick_data = in_data[i*W +: W];
      in_ready[i] = fire && (grant == SW'(i));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr     <= '0;
      err_sel <= 1'b0;
    end else begin
      err_sel <= drop;
      if (ARB == MODE_RR && fire) begin
        ptr <= (int'(grant) == N - 1) ? '0 : grant + 1'b1;
      end
    end
  end

  hs_skid2 #(
    .DW (W + SW)
  ) u_skid (
    .clk       (clk),
    .rst       (rst),
    .push      (fire),
    .push_data ({pick_data, grant}),
    .pop       (out_ready),
    .head      (head),
    .valid     (out_valid),
    .count     (count)
  );

  assign {out_data, out_src} = head;

endmodule

// File: tb/tb_mux_n_hs.sv
// Bench for mux_n_hs: select mode (N=4, N=3) and round-robin mode (N=4)
// instances, with a queue scoreboard per instance checked by output monitors.
module tb_mux_n_hs;

  typedef struct packed {
    logic [7:0] data;
    logic [1:0] src;
  } ent_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  ent_t exp_a[$];
  ent_t exp_b[$];
  ent_t exp_c[$];

  logic        a_sel_valid, a_sel_ready, a_out_valid, a_out_ready, a_err_sel;
  logic [1:0]  a_sel_data, a_out_src;
  logic [3:0]  a_in_valid, a_in_ready;
  logic [31:0] a_in_data;
  logic [7:0]  a_out_data;

  logic        b_sel_valid, b_sel_ready, b_out_valid, b_out_ready, b_err_sel;
  logic [1:0]  b_sel_data, b_out_src;
  logic [2:0]  b_in_valid, b_in_ready;
  logic [23:0] b_in_data;
  logic [7:0]  b_out_data;

  logic        c_sel_valid, c_sel_ready, c_out_valid, c_out_ready, c_err_sel;
  logic [1:0]  c_sel_data, c_out_src;
  logic [3:0]  c_in_valid, c_in_ready;
  logic [31:0] c_in_data;
  logic [7:0]  c_out_data;

  mux_n_hs #(.N(4), .W(8), .ARB(0)) u_a (
    .clk(clk), .rst(rst),
    .sel_valid(a_sel_valid), .sel_ready(a_sel_ready), .sel_data(a_sel_data),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
    .out_src(a_out_src), .err_sel(a_err_sel)
  );

  mux_n_hs #(.N(3), .W(8), .ARB(0)) u_b (
    .clk(clk), .rst(rst),
    .sel_valid(b_sel_valid), .sel_ready(b_sel_ready), .sel_data(b_sel_data),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
    .out_src(b_out_src), .err_sel(b_err_sel)
  );

  mux_n_hs #(.N(4), .W(8), .ARB(1)) u_c (
    .clk(clk), .rst(rst),
    .sel_valid(c_sel_valid), .sel_ready(c_sel_ready), .sel_data(c_sel_data),
    .in_valid(c_in_valid), .in_ready(c_in_ready), .in_data(c_in_data),
    .out_valid(c_out_valid), .out_ready(c_out_ready), .out_data(c_out_data),
    .out_src(c_out_src), .err_sel(c_err_sel)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Output monitors: every accepted output word must match the queue head.
  always @(negedge clk) begin
    ent_t e;
    if (!rst && a_out_valid && a_out_ready) begin
      if (exp_a.size() == 0) begin
        checks++; errors++;
        $display("FAIL a_pop unexpected word actual=%0h required=none", a_out_data);
      end else begin
        e = exp_a.pop_front();
        chk("a_out_data", 32'(a_out_data), 32'(e.data));
        chk("a_out_src", 32'(a_out_src), 32'(e.src));
      end
    end
  end

  always @(negedge clk) begin
    ent_t e;
    if (!rst && b_out_valid && b_out_ready) begin
      if (exp_b.size() == 0) begin
        checks++; errors++;
        $display("FAIL b_pop unexpected word actual=%0h required=none", b_out_data);
      end else begin
        e = exp_b.pop_front();
        chk("b_out_data", 32'(b_out_data), 32'(e.data));
        chk("b_out_src", 32'(b_out_src), 32'(e.src));
      end
    end
  end

  always @(negedge clk) begin
    ent_t e;
    if (!rst && c_out_valid && c_out_ready) begin
      if (exp_c.size() == 0) begin
        checks++; errors++;
        $display("FAIL c_pop unexpected word actual=%0h required=none", c_out_data);
      end else begin
        e = exp_c.pop_front();
        chk("c_out_data", 32'(c_out_data), 32'(e.data));
        chk("c_out_src", 32'(c_out_src), 32'(e.src));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int        tok;
    logic      fired;
    logic [7:0] bp_fire;
    logic [1:0] rr_seq [9];
    logic [7:0] dat;

    // Handshakes presented during reset must stay blocked.
    a_sel_valid = 1'b1; a_sel_data = 2'd0; a_in_valid = 4'hF; a_in_data = '0; a_out_ready = 1'b1;
    b_sel_valid = 1'b1; b_sel_data = 2'd3; b_in_valid = 3'h7; b_in_data = '0; b_out_ready = 1'b1;
    c_sel_valid = 1'b1; c_sel_data = 2'd0; c_in_valid = 4'hF; c_in_data = '0; c_out_ready = 1'b1;
    rst = 1'b1;
    step();
    @(negedge clk);
    chk("rst_a_sel_ready", 32'(a_sel_ready), 0);
    chk("rst_a_in_ready", 32'(a_in_ready), 0);
    chk("rst_a_out_valid", 32'(a_out_valid), 0);
    chk("rst_a_out_data", 32'(a_out_data), 0);
    chk("rst_a_out_src", 32'(a_out_src), 0);
    chk("rst_a_err_sel", 32'(a_err_sel), 0);
    chk("rst_b_sel_ready", 32'(b_sel_ready), 0);
    chk("rst_c_in_ready", 32'(c_in_ready), 0);
    step();
    rst = 1'b0;
    a_sel_valid = 1'b0; a_in_valid = '0;
    b_sel_valid = 1'b0; b_in_valid = '0; b_out_ready = 1'b0;
    c_sel_valid = 1'b1; c_in_valid = '0;

    // Basic select: channel 2 carrying A5.
    a_sel_valid = 1'b1; a_sel_data = 2'd2; a_in_valid = 4'b0100; a_in_data = 32'h00A5_0000;
    @(negedge clk);
    chk("basic_in_ready", 32'(a_in_ready), 32'h4);
    chk("basic_sel_ready", 32'(a_sel_ready), 1);
    exp_a.push_back('{data: 8'hA5, src: 2'd2});
    step();
    a_sel_valid = 1'b0; a_in_valid = '0;
    @(negedge clk);
    chk("basic_out_valid", 32'(a_out_valid), 1);
    step();

    // Select token for channel 1 waits while only channel 0 is valid.
    a_sel_valid = 1'b1; a_sel_data = 2'd1; a_in_valid = 4'b0001; a_in_data = 32'h0000_3C11;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("wait_in_ready", 32'(a_in_ready), 0);
      chk("wait_sel_ready", 32'(a_sel_ready), 0);
      step();
    end
    a_in_valid = 4'b0011;
    @(negedge clk);
    chk("wait_fire_in_ready", 32'(a_in_ready), 32'h2);
    chk("wait_fire_sel_ready", 32'(a_sel_ready), 1);
    exp_a.push_back('{data: 8'h3C, src: 2'd1});
    step();
    a_sel_valid = 1'b0; a_in_valid = '0;
    step();

    // Backpressure: 5 tokens, consumer stalled for the first 4 cycles.
    bp_fire = 8'b1110_0011;
    tok = 0;
    a_in_valid = 4'hF;
    for (int cyc = 0; cyc < 8; cyc++) begin
      a_out_ready = (cyc >= 4);
      a_sel_valid = 1'b1;
      a_sel_data  = 2'(tok % 4);
      dat = 8'(8'h60 + tok);
      a_in_data = {4{dat}};
      @(negedge clk);
      fired = (a_in_ready != 4'h0);
      if (cyc == 3) chk("bp_absorbed", 32'(tok), 2);
      chk("bp_fire", 32'(fired), 32'(bp_fire[cyc]));
      if (fired) begin
        chk("bp_onehot", 32'(a_in_ready), 32'(4'b0001 << (tok % 4)));
        exp_a.push_back('{data: dat, src: 2'(tok % 4)});
        tok++;
      end
      step();
    end
    chk("bp_total", 32'(tok), 5);
    a_sel_valid = 1'b0; a_in_valid = '0;
    repeat (3) step();

    // Out-of-range select on N=3: one word buffered, then a token for index 3.
    b_sel_valid = 1'b1; b_sel_data = 2'd0; b_in_valid = 3'b001; b_in_data = 24'h00_0077;
    @(negedge clk);
    chk("oor_pre_in_ready", 32'(b_in_ready), 32'h1);
    exp_b.push_back('{data: 8'h77, src: 2'd0});
    step();
    b_sel_data = 2'd3; b_in_valid = 3'b111;
    @(negedge clk);
    chk("oor_sel_ready", 32'(b_sel_ready), 1);
    chk("oor_in_ready", 32'(b_in_ready), 0);
    chk("oor_err_early", 32'(b_err_sel), 0);
    step();
    b_sel_valid = 1'b0; b_in_valid = '0;
    @(negedge clk);
    chk("oor_err_pulse", 32'(b_err_sel), 1);
    chk("oor_out_valid", 32'(b_out_valid), 1);
    step();
    @(negedge clk);
    chk("oor_err_clear", 32'(b_err_sel), 0);
    step();
    b_out_ready = 1'b1;
    step();
    @(negedge clk);
    chk("oor_count_unchanged", 32'(b_out_valid), 0);
    step();

    // Round-robin: all valid gives 0,1,2,3,0; then channels 1,3 give 1,3,1,3.
    rr_seq = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd3, 2'd1, 2'd3};
    c_out_ready = 1'b1;
    c_in_data = 32'hC3C2_C1C0;
    for (int k = 0; k < 9; k++) begin
      c_in_valid = (k < 5) ? 4'b1111 : 4'b1010;
      @(negedge clk);
      chk("rr_in_ready", 32'(c_in_ready), 32'(4'b0001 << rr_seq[k]));
      chk("rr_sel_ready", 32'(c_sel_ready), 0);
      exp_c.push_back('{data: 8'(8'hC0 + rr_seq[k]), src: rr_seq[k]});
      step();
    end
    c_in_valid = '0;
    repeat (2) step();

    // Reset with both A and C holding two words; C's pointer left at 2.
    a_out_ready = 1'b0; a_sel_valid = 1'b1; a_sel_data = 2'd0; a_in_valid = 4'b0001; a_in_data = 32'h0000_00EE;
    c_out_ready = 1'b0; c_in_valid = 4'b0010;
    repeat (2) step();
    a_sel_valid = 1'b0; a_in_valid = '0; c_in_valid = '0;
    @(negedge clk);
    chk("pre_rst_a_valid", 32'(a_out_valid), 1);
    chk("pre_rst_c_valid", 32'(c_out_valid), 1);
    step();
    rst = 1'b1;
    exp_a.delete();
    exp_c.delete();
    a_sel_valid = 1'b1; a_in_valid = 4'b0001;
    b_sel_valid = 1'b1; b_sel_data = 2'd3;
    c_in_valid = 4'hF;
    @(negedge clk);
    chk("midrst_a_in_ready", 32'(a_in_ready), 0);
    chk("midrst_b_sel_ready", 32'(b_sel_ready), 0);
    chk("midrst_c_in_ready", 32'(c_in_ready), 0);
    step();
    rst = 1'b0;
    a_sel_valid = 1'b0; a_in_valid = '0;
    b_sel_valid = 1'b0;
    c_out_ready = 1'b1; c_in_valid = 4'hF;
    @(negedge clk);
    chk("postrst_a_out_valid", 32'(a_out_valid), 0);
    chk("postrst_a_out_data", 32'(a_out_data), 0);
    chk("postrst_b_err_sel", 32'(b_err_sel), 0);
    chk("postrst_c_out_valid", 32'(c_out_valid), 0);
    chk("postrst_c_grant", 32'(c_in_ready), 32'h1);
    exp_c.push_back('{data: 8'hC0, src: 2'd0});
    step();
    c_in_valid = '0;
    @(negedge clk);
    chk("postrst_c_out_valid1", 32'(c_out_valid), 1);
    repeat (3) step();

    chk("a_queue_empty", 32'(exp_a.size()), 0);
    chk("b_queue_empty", 32'(exp_b.size()), 0);
    chk("c_queue_empty", 32'(exp_c.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
